// File: rtl/mips_step_ctrl.sv
// Front-panel run/step controller for the MIPS core: synchronizes and debounces two buttons, toggles run_mode, issues step pulses.
// Optional build macro STEP_AUTOREPEAT_EN: a held step button re-issues a step every REPEAT_CYCLES+1 cycles.
module mips_step_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16,
  parameter bit          RUN_DEFAULT     = 1'b1,
  parameter int unsigned REPEAT_CYCLES   = 25000000,
  parameter int unsigned REP_W           = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_step,
  input  logic       btn_mode,
  output logic       step,
  output logic       run_mode,
  output logic [7:0] step_count
);

  typedef enum logic [1:0] {IDLE, PULSE, HELD} state_t;

  // Counter widths must be able to reach their terminal values.
  if (DEBOUNCE_CYCLES < 1 || 64'(DEBOUNCE_CYCLES) > (64'd1 << CNT_W)) begin : g_bad_cnt_w
    $error("CNT_W too small for DEBOUNCE_CYCLES");
  end
  if (REPEAT_CYCLES < 1 || 64'(REPEAT_CYCLES) > (64'd1 << REP_W)) begin : g_bad_rep_w
    $error("REP_W too small for REPEAT_CYCLES");
  end

  // Bit 0 = step button, bit 1 = mode button.
  logic [1:0]            sync1_q, sync2_q;
  logic [1:0]            stable_q, stable_d;
  logic [1:0]            prev_q;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]            press;
  logic                  step_press, mode_press;

  logic                  run_mode_q, run_mode_d;
  state_t                state_q, state_d;
  logic [7:0]            step_count_q, step_count_d;
`ifdef STEP_AUTOREPEAT_EN
  logic [REP_W-1:0]      rep_q, rep_d;
`endif

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_d[i] = ~stable_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  assign press      = stable_q & ~prev_q;
  assign step_press = press[0];
  assign mode_press = press[1];
  assign run_mode_d = run_mode_q ^ mode_press;

  // step is a bare one-cycle strobe with no back-pressure: the core must act on every cycle it is high.
  always_comb begin
    state_d      = state_q;
    step_count_d = step_count_q;
`ifdef STEP_AUTOREPEAT_EN
    rep_d        = rep_q;
`endif
    case (state_q)
      IDLE: begin
        if (step_press && !run_mode_q && !mode_press) state_d = PULSE;
      end
      PULSE: begin
        step_count_d = step_count_q + 8'd1;
        state_d      = HELD;
`ifdef STEP_AUTOREPEAT_EN
        rep_d        = '0;
`endif
      end
      HELD: begin
        if (!stable_q[0]) begin
          state_d = IDLE;
`ifdef STEP_AUTOREPEAT_EN
        end else if (run_mode_q) begin
          rep_d = '0;
        end else if (rep_q == REP_W'(REPEAT_CYCLES - 1)) begin
          state_d = PULSE;
          rep_d   = '0;
        end else begin
          rep_d = rep_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      prev_q       <= '0;
      cnt_q        <= '0;
      run_mode_q   <= RUN_DEFAULT;
      state_q      <= IDLE;
      step_count_q <= '0;
`ifdef STEP_AUTOREPEAT_EN
      rep_q        <= '0;
`endif
    end else begin
      sync1_q      <= {btn_mode, btn_step};
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      prev_q       <= stable_q;
      cnt_q        <= cnt_d;
      run_mode_q   <= run_mode_d;
      state_q      <= state_d;
      step_count_q <= step_count_d;
`ifdef STEP_AUTOREPEAT_EN
      rep_q        <= rep_d;
`endif
    end
  end

  assign step       = (state_q == PULSE);
  assign run_mode   = run_mode_q;
  assign step_count = step_count_q;

endmodule

// File: tb/tb_mips_step_ctrl.sv
// Bench for mips_step_ctrl (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8): expected step pulses are queued as {cycle, count}.
`timescale 1ns/1ps
module tb_mips_step_ctrl;

  localparam int W = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_step = 1'b0;
  logic       btn_mode = 1'b0;
  logic       step;
  logic       run_mode;
  logic [7:0] step_count;

  int unsigned  cyc = 0;
  int           tests = 0;
  int           fails = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0]   exp_cnt = 8'd0;

  mips_step_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(16),
    .RUN_DEFAULT(1'b1),
    .REPEAT_CYCLES(8),
    .REP_W(25)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_step(btn_step),
    .btn_mode(btn_mode),
    .step(step),
    .run_mode(run_mode),
    .step_count(step_count)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // First sample of a button driven now is edge cyc+1; step must rise on edge cyc+7.
  task automatic expect_pulse(input int unsigned at);
    exp_q.push_back({at[31:0], exp_cnt});
    exp_cnt = exp_cnt + 8'd1;
  endtask

  task automatic press_step(input int hi, input int lo, input bit want);
    if (want) expect_pulse(cyc + 7);
    btn_step = 1'b1;
    tick(hi);
    btn_step = 1'b0;
    tick(lo);
  endtask

  task automatic press_mode(input int hi, input int lo);
    btn_mode = 1'b1;
    tick(hi);
    btn_mode = 1'b0;
    tick(lo);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (step) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_step: pulse at cycle %0d count %0d, no pulse required", cyc, step_count);
      end else begin
        e = exp_q.pop_front();
        if ({cyc, step_count} !== e) begin
          fails++;
          $display("FAIL step_pulse: got cycle %0d count %0d, expected cycle %0d count %0d",
                   cyc, step_count, e[39:8], e[7:0]);
        end
      end
    end
  end

  // Stimulus
  initial begin
    int unsigned k;
    tick(3);
    check("reset_step", step, 0);
    check("reset_run_mode", run_mode, 1);
    check("reset_count", step_count, 0);
    rst = 1'b1;
    tick(2);
    check("post_reset_run_mode", run_mode, 1);
    check("post_reset_count", step_count, 0);

    // 1: step press in run mode is discarded
    press_step(20, 12, 1'b0);
    check("run_mode_step_count", step_count, 0);
    check("run_mode_held", run_mode, 1);

    // 2: mode toggle, then one step with fixed latency
    press_mode(10, 12);
    check("mode_toggle_once", run_mode, 0);
    press_step(20, 12, 1'b1);
    check("first_step_count", step_count, 1);

    // 3: 3-cycle glitches are filtered
    repeat (7) begin
      btn_step = 1'b1;
      tick(3);
      btn_step = 1'b0;
      tick(3);
    end
    tick(10);
    check("glitch_count", step_count, 1);

    // 4: 256 clean presses, counter wraps
    repeat (255) press_step(8, 8, 1'b1);
    check("count_wrap_zero", step_count, 0);
    press_step(8, 8, 1'b1);
    check("count_after_256", step_count, 1);
    btn_step = 1'b1;
    btn_mode = 1'b1;
    tick(10);
    btn_step = 1'b0;
    btn_mode = 1'b0;
    tick(12);
    check("same_cycle_mode_wins", run_mode, 1);
    check("same_cycle_no_step", step_count, 1);
    press_mode(10, 12);
    check("back_to_step_mode", run_mode, 0);

    // 5: reset during PULSE, button held through release
    expect_pulse(cyc + 7);
    btn_step = 1'b1;
    tick(7);
    #1 rst = 1'b0;
    #1;
    check("async_reset_step", step, 0);
    check("async_reset_count", step_count, 0);
    check("async_reset_run_mode", run_mode, 1);
    exp_cnt = 8'd0;
    @(negedge clk);
    rst = 1'b1;
    tick(20);
    check("held_after_reset_run", run_mode, 1);
    press_mode(10, 12);
    check("held_mode_toggle", run_mode, 0);
    check("held_no_step", step_count, 0);
    btn_step = 1'b0;
    tick(12);
    press_step(8, 8, 1'b1);
    check("repress_count", step_count, 1);

    // 6: long hold
    k = cyc;
`ifdef STEP_AUTOREPEAT_EN
    for (int i = 0; i < 5; i++) expect_pulse(k + 7 + 9 * i);
`else
    expect_pulse(k + 7);
`endif
    btn_step = 1'b1;
    tick(40);
    btn_step = 1'b0;
    tick(20);
`ifdef STEP_AUTOREPEAT_EN
    check("long_hold_count", step_count, 6);
`else
    check("long_hold_count", step_count, 2);
`endif

    tick(5);
    check("pending_pulses", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
